// File: rtl/sdram_arbiter.sv
// Four-master arbiter in front of a single-port SDRAM controller: registered
// request towards the controller, combinational ack and read-return decode.
module sdram_arbiter #(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [3:0]   m_request,
    input  logic [3:0]   m_write,
    input  logic [3:0]   m_burst,
    input  logic [103:0] m_address,
    input  logic [127:0] m_wdata,
    input  logic [15:0]  m_byte_en,
    output logic [3:0]   m_ack,
    output logic [3:0]   m_rvalid,
    output logic [3:0]   m_complete,
    output logic [31:0]  m_rdata,
    output logic         sdram_request,
    output logic         sdram_write,
    output logic         sdram_burst,
    output logic [3:0]   sdram_master,
    output logic [25:0]  sdram_address,
    output logic [31:0]  sdram_wdata,
    output logic [3:0]   sdram_byte_en,
    input  logic         sdram_ready,
    input  logic [31:0]  sdram_rdata,
    input  logic [3:0]   sdram_valid,
    input  logic [3:0]   sdram_complete
);

    typedef enum logic {ARB_IDLE, ARB_GRANT} state_t;

    state_t     state, state_next;
    logic [3:0] read_busy;
    logic [3:0] eligible;
    logic [1:0] rr_ptr;
    logic [1:0] winner;
    logic [1:0] idx;
    logic       found;
    logic       accept;

    // A master with a read in flight may still issue writes.
    assign eligible = m_request & (m_write | ~read_busy);

    // NOTE: every variable written in an always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        winner = 2'd0;
        found  = 1'b0;
        idx    = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = 2'(k) + ((FIXED_PRIORITY != 0) ? 2'd0 : rr_ptr);
            if (!found && eligible[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign accept = (state == ARB_GRANT) && sdram_request && sdram_ready;

    always_comb begin
        m_ack      = 4'b0;
        m_rvalid   = 4'b0;
        m_complete = 4'b0;
        for (int i = 0; i < 4; i++) begin
            m_ack[i]      = accept && !reset && (sdram_master == 4'(i + 1));
            m_rvalid[i]   = (sdram_valid == 4'(i + 1));
            m_complete[i] = (sdram_complete == 4'(i + 1));
        end
    end

    assign m_rdata = sdram_rdata;

    // NOTE: sequential state is always assigned with non-blocking <= so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ARB_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE:  if (found)  state_next = ARB_GRANT;
            ARB_GRANT: if (accept) state_next = ARB_IDLE;
            default:   state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sdram_request <= 1'b0;
            sdram_write   <= 1'b0;
            sdram_burst   <= 1'b0;
            sdram_master  <= 4'd0;
            sdram_address <= 26'd0;
            sdram_wdata   <= 32'd0;
            sdram_byte_en <= 4'd0;
        end else if (state == ARB_IDLE && found) begin
            sdram_request <= 1'b1;
            sdram_write   <= m_write[winner];
            sdram_burst   <= m_burst[winner];
            sdram_master  <= {2'b00, winner} + 4'd1;
            sdram_address <= {m_address[26 * int'(winner) + 2 +: 24], 2'b00};
            sdram_wdata   <= m_wdata[32 * int'(winner) +: 32];
            sdram_byte_en <= m_byte_en[4 * int'(winner) +: 4];
        end else if (accept) begin
            sdram_request <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr    <= 2'd0;
            read_busy <= 4'b0;
        end else begin
            // Master ID is winner+1, so its low two bits are already (winner+1) mod 4.
            if (accept && FIXED_PRIORITY == 0) rr_ptr <= sdram_master[1:0];
            read_busy <= (read_busy & ~m_complete) | (m_ack & {4{~sdram_write}});
        end
    end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter FIXED_PRIORITY, default 0, selects arbitration: 0 = round-robin, 1 = fixed priority with master 0 highest.
REQ-002 clock  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  reset is asynchronous and active-high.
REQ-004 m_request  input  4  bit i high while master i requests a transaction; held stable until m_ack[i].
REQ-005 m_write  input  4  bit i set for a write from master i.
REQ-006 m_burst  input  4  bit i set for a 32-byte read burst from master i.
REQ-007 m_address  input  104  master i address in bits [26i+25:26i]; bits [1:0] ignored.
REQ-008 m_wdata  input  128  master i write data in bits [32i+31:32i].
REQ-009 m_byte_en  input  16  master i byte enables in bits [4i+3:4i].
REQ-010 m_ack  output  4  bit i pulses for one cycle when the SDRAM controller accepts master i's transaction.
REQ-011 m_rvalid  output  4  bit i pulses when m_rdata holds a read word for master i.
REQ-012 m_complete  output  4  bit i pulses when master i's read transaction finishes.
REQ-013 m_rdata  output  32  read data, broadcast to all masters.
REQ-014 sdram_request, sdram_write, sdram_burst  output  1 each  registered request to the SDRAM controller.
REQ-015 sdram_master  output  4  registered ID of the granted master, equal to i+1; 0 is never issued.
REQ-016 sdram_address  output  26  registered address; sdram_wdata output 32; sdram_byte_en output 4.
REQ-017 sdram_ready  input  1  SDRAM controller accepts the presented request in any cycle where sdram_request and sdram_ready are both high.
REQ-018 sdram_rdata  input  32  read data from the controller; sdram_valid input 4; sdram_complete input 4; both carry the master ID, with 0 meaning none.

Function
REQ-019 FSM has 2 states: ARB_IDLE and ARB_GRANT.
REQ-020 Master i is eligible when m_request[i] is high and NOT (m_write[i] low and read_busy[i] high).
REQ-021 ARB_IDLE, with at least one eligible master, SHALL:
  - pick a winner;
  - register that master's write, burst, address, wdata and byte_en fields onto the sdram_* outputs;
  - set sdram_master = winner+1 and sdram_request = 1;
  - go to ARB_GRANT.
REQ-022 ARB_IDLE with no eligible master keeps sdram_request = 0; the other sdram_* outputs hold their values.
REQ-023 Round-robin mode searches from rr_ptr upward, modulo 4; rr_ptr becomes winner+1 (mod 4) when the transaction is accepted.
REQ-024 Fixed-priority mode always picks the lowest-numbered eligible master; rr_ptr is unused.
REQ-025 ARB_GRANT holds all sdram_* outputs stable until accept (sdram_request && sdram_ready).
REQ-026 In the accept cycle the arbiter SHALL:
  - drive m_ack[winner] = 1 combinationally;
  - at the clock edge, clear sdram_request and return to ARB_IDLE.
REQ-027 There is exactly one idle cycle between an accept and the next sdram_request assertion.
REQ-028 Accepting a read from master i sets read_busy[i]; sdram_complete == i+1 clears it.
REQ-029 Set and clear of the same read_busy bit cannot coincide, because a new read from that master is ineligible while its bit is set.
REQ-030 Writes are never blocked by read_busy.
REQ-031 Read-return decode is combinational:
  - m_rvalid[i] = (sdram_valid == i+1);
  - m_complete[i] = (sdram_complete == i+1);
  - m_rdata = sdram_rdata.
REQ-032 sdram_valid or sdram_complete values of 0 or above 4 drive no m_rvalid or m_complete bit.
REQ-033 m_request dropping without an ack is a protocol violation and need not be handled; the arbiter still completes the grant already issued.

Reset
REQ-034 On reset assertion, without waiting for a clock edge:
  - state = ARB_IDLE;
  - sdram_request, sdram_write and sdram_burst = 0;
  - sdram_master, sdram_address, sdram_wdata and sdram_byte_en = 0;
  - rr_ptr = 0 and read_busy = 0.
REQ-035 m_ack is 0 while reset is high.
REQ-036 Reset asserted during ARB_GRANT drops sdram_request immediately and abandons the transaction; no m_ack is issued.

Verification
REQ-037 Write from master 2 only:
  - stimulus: m_request = 4'b0100, addr 0x0001234, data 0xDEADBEEF, be 0xF;
  - response: the next cycle shows sdram_master = 3, sdram_write = 1 and those fields;
  - response: with ready held low for 3 cycles, outputs stay stable and m_ack[2] pulses exactly once when ready rises.
REQ-038 Round-robin with all 4 masters requesting writes continuously and ready = 1: grant order is 1,2,3,4,1 on sdram_master, with one idle cycle between grants.
REQ-039 FIXED_PRIORITY = 1, masters 0 and 3 requesting: master 0 wins every arbitration until it drops its request, then master 3 is granted.
REQ-040 Master 1 read-busy blocking:
  - stimulus: master 1 read is accepted, then master 1 issues a second read request;
  - response: no grant is issued to master 1 until sdram_complete = 2;
  - response: a write from master 1 during that time is granted.
REQ-041 Read-return routing:
  - stimulus: sdram_valid = 3 with sdram_rdata = 0x12345678;
  - response: m_rvalid = 4'b0100 and m_rdata = 0x12345678;
  - stimulus: sdram_valid = 0;
  - response: m_rvalid = 0.
REQ-042 Reset mid-grant:
  - stimulus: assert reset while in ARB_GRANT with ready low;
  - response: sdram_request falls before the next clock edge and no m_ack is issued;
  - response: after release, rr_ptr restarts so master 0 is searched first.
